// File: rtl/oc_vector_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : oc_vector_checker_if
// Description : Bundles the signals that run between the vector checker and
//               its environment: the start request, the stimulus driven into
//               the block under test (a, b, c), the responses read back
//               (y0, y1) and the run status and result outputs.
//               master : the checker side (drives stimulus and results)
//               slave  : the environment side (drives start and y0/y1)
// Revision    : 1.0  initial release
// ============================================================================
interface oc_vector_checker_if;
  logic       start;      // single-cycle run request
  logic       y0;         // response y0 from the block under test
  logic       y1;         // response y1 from the block under test
  logic       a;          // stimulus MSB
  logic       b;          // stimulus middle bit
  logic       c;          // stimulus LSB
  logic       busy;       // run in progress
  logic       mismatch;   // pulse on a failing sample cycle
  logic       done;       // pulse when a run completes
  logic       pass;       // 1 iff the last run had no failing vector
  logic [3:0] err_count;  // number of failing vectors (0..8)
  logic [7:0] fail_vec;   // bit i set when vector i failed

  modport master (
    input  start, y0, y1,
    output a, b, c, busy, mismatch, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, y0, y1,
    input  a, b, c, busy, mismatch, done, pass, err_count, fail_vec
  );
endinterface
`default_nettype wire

// File: rtl/oc_vector_checker.sv
`default_nettype none
// ============================================================================
// Module      : oc_vector_checker
// Description : Exhaustive stimulus/response checker for a 3-input, 2-output
//               combinational block. On start it walks {a,b,c} through 0..7,
//               holding each vector HOLD_CYCLES cycles and sampling y0/y1 on
//               the last cycle of each hold against the EXP_Y0/EXP_Y1 truth
//               tables. Results: per-vector fail mask, failing-vector count
//               and a pass flag that holds until the next accepted start.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - oc_vector_checker_if.master (start, y0, y1 in;
//                      a, b, c, busy, mismatch, done, pass, err_count,
//                      fail_vec out)
// Revision    : 1.0  initial release
// ============================================================================
module oc_vector_checker #(
  parameter int unsigned HOLD_CYCLES = 79,     // legal range 2..255
  parameter logic [7:0]  EXP_Y0      = 8'h96,  // bit i = expected y0 at vector i
  parameter logic [7:0]  EXP_Y1      = 8'hE8   // bit i = expected y1 at vector i
) (
  input  wire logic            clk,
  input  wire logic            rst,
  oc_vector_checker_if.master  bus
);

  // Counter only ever needs to reach HOLD_CYCLES-1.
  localparam int unsigned         c_CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         idx_q,   idx_d;
  logic [c_CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]         abc_q,   abc_d;
  logic [3:0]         err_q,   err_d;
  logic [7:0]         fail_q,  fail_d;
  logic               pass_q,  pass_d;
  logic               w_sample;
  logic               w_mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      abc_q   <= 3'd0;
      err_q   <= 4'd0;
      fail_q  <= 8'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    abc_d      = abc_q;
    err_d      = err_q;
    fail_d     = fail_q;
    pass_d     = pass_q;
    w_sample   = 1'b0;
    w_mismatch = 1'b0;

    case (state_q)
      IDLE: begin
        abc_d = 3'd0;
        if (bus.start) begin
          err_d   = 4'd0;
          fail_d  = 8'd0;
          pass_d  = 1'b0;
          idx_d   = 3'd0;
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end

      DRIVE: begin
        cnt_d    = cnt_q + 1'b1;
        w_sample = (cnt_q == c_LAST);
        if (w_sample) begin
          // A vector counts once even if both outputs are wrong.
          w_mismatch = (bus.y0 != EXP_Y0[idx_q]) || (bus.y1 != EXP_Y1[idx_q]);
          if (w_mismatch) begin
            fail_d[idx_q] = 1'b1;
            err_d         = err_q + 4'd1;
          end
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            // pass must already be valid during the done cycle, so fold in
            // the outcome of this final sample directly.
            pass_d  = (err_q == 4'd0) && !w_mismatch;
            abc_d   = 3'd0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 3'd1;
            abc_d = idx_q + 3'd1;
          end
        end
      end

      DONE: begin
        abc_d   = 3'd0;
        state_d = IDLE;
      end

      default: begin
        abc_d   = 3'd0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.a         = abc_q[2];
  assign bus.b         = abc_q[1];
  assign bus.c         = abc_q[0];
  assign bus.busy      = (state_q == DRIVE);
  assign bus.done      = (state_q == DONE);
  assign bus.mismatch  = w_mismatch;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_oc_vector_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_oc_vector_checker
// Description : Directed self-checking bench for oc_vector_checker. One
//               instance uses the default parameters against a behavioural
//               block whose fault mode is selectable; a second instance uses
//               HOLD_CYCLES=2 against a correct block.
// Revision    : 1.0  initial release
// ============================================================================
module tb_oc_vector_checker;

  localparam int c_H0 = 79;
  localparam int c_H1 = 2;

  logic clk;
  logic rst;
  int   mode;       // 0 = correct, 1 = y0 stuck at 0, 2 = both inverted
  int   n_cmp;
  int   n_err;

  // run observations
  int         done_n;
  int         mm_cnt;
  logic [7:0] mm_mask;

  oc_vector_checker_if intf0 ();
  oc_vector_checker_if intf1 ();

  oc_vector_checker u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (intf0.master)
  );

  oc_vector_checker #(
    .HOLD_CYCLES (c_H1),
    .EXP_Y0      (8'h96),
    .EXP_Y1      (8'hE8)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (intf1.master)
  );

  // Behavioural blocks under test: y0 = parity, y1 = majority.
  wire w_par0 = intf0.a ^ intf0.b ^ intf0.c;
  wire w_maj0 = (intf0.a & intf0.b) | (intf0.a & intf0.c) | (intf0.b & intf0.c);
  assign intf0.y0 = (mode == 1) ? 1'b0 : (mode == 2) ? ~w_par0 : w_par0;
  assign intf0.y1 = (mode == 2) ? ~w_maj0 : w_maj0;

  assign intf1.y0 = intf1.a ^ intf1.b ^ intf1.c;
  assign intf1.y1 = (intf1.a & intf1.b) | (intf1.a & intf1.c) | (intf1.b & intf1.c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on dut0 and follow the run at negedges. n counts cycles
  // after the start cycle. Optionally re-pulse start at cycle repulse_n, or
  // assert rst at cycle rst_n (returns right after asserting it).
  task automatic run0(input int md, input int repulse_n, input int rst_n);
    int n;
    mode    = md;
    done_n  = 0;
    mm_cnt  = 0;
    mm_mask = 8'd0;
    intf0.start = 1'b1;
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      intf0.start = (n == repulse_n);
      if (n == rst_n) begin
        rst = 1'b1;
        break;
      end
      if ((n - 1) % c_H0 == 0 && n <= 8 * c_H0)
        check("abc_step", {29'd0, intf0.a, intf0.b, intf0.c}, (n - 1) / c_H0);
      if (intf0.mismatch) begin
        mm_cnt++;
        mm_mask = mm_mask | (8'd1 << {intf0.a, intf0.b, intf0.c});
      end
      if (intf0.done) begin
        done_n = n;
        break;
      end
    end
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    mode  = 0;
    rst   = 1'b1;
    intf0.start = 1'b0;
    intf1.start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_abc",  {29'd0, intf0.a, intf0.b, intf0.c}, 0);
    check("rst_busy", intf0.busy, 0);
    check("rst_done", intf0.done, 0);
    check("rst_pass", intf0.pass, 0);
    check("rst_err",  intf0.err_count, 0);
    check("rst_fail", intf0.fail_vec, 0);
    check("rst_mm",   intf0.mismatch, 0);
    rst = 1'b0;
    @(negedge clk);

    // Clean run, default parameters
    run0(0, 0, 0);
    check("clean_done_at", done_n, 1 + 8 * c_H0);
    check("clean_pass", intf0.pass, 1);
    check("clean_busy_in_done", intf0.busy, 0);
    check("clean_err", intf0.err_count, 0);
    check("clean_fail", intf0.fail_vec, 8'h00);
    check("clean_mm_cnt", mm_cnt, 0);
    @(negedge clk);
    check("clean_done_pulse", intf0.done, 0);
    check("clean_pass_hold", intf0.pass, 1);

    // y0 stuck at 0: vectors 1,2,4,7 fail
    run0(1, 0, 0);
    check("stuck_done_at", done_n, 633);
    check("stuck_err", intf0.err_count, 4);
    check("stuck_fail", intf0.fail_vec, 8'h96);
    check("stuck_pass", intf0.pass, 0);
    check("stuck_mm_cnt", mm_cnt, 4);
    check("stuck_mm_mask", mm_mask, 8'h96);
    @(negedge clk);

    // Both outputs inverted; also request start during the done cycle
    run0(2, 0, 0);
    check("inv_err", intf0.err_count, 8);
    check("inv_fail", intf0.fail_vec, 8'hFF);
    check("inv_pass", intf0.pass, 0);
    check("inv_mm_cnt", mm_cnt, 8);
    intf0.start = 1'b1;
    @(negedge clk);
    intf0.start = 1'b0;
    check("start_in_done_busy", intf0.busy, 0);
    check("start_in_done_err", intf0.err_count, 8);
    @(negedge clk);
    check("start_in_done_idle", intf0.busy, 0);

    // start re-pulsed during vector 3 of a failing run: ignored
    run0(1, 1 + 3 * c_H0 + 5, 0);
    check("repulse_done_at", done_n, 633);
    check("repulse_err", intf0.err_count, 4);
    check("repulse_fail", intf0.fail_vec, 8'h96);
    check("repulse_mm_cnt", mm_cnt, 4);
    @(negedge clk);
    check("repulse_busy_after", intf0.busy, 0);

    // rst during vector 5 of a failing run
    run0(1, 0, 1 + 5 * c_H0 + 3);
    @(negedge clk);
    check("abort_abc",  {29'd0, intf0.a, intf0.b, intf0.c}, 0);
    check("abort_busy", intf0.busy, 0);
    check("abort_done", intf0.done, 0);
    check("abort_err",  intf0.err_count, 0);
    check("abort_fail", intf0.fail_vec, 0);
    check("abort_pass", intf0.pass, 0);
    rst = 1'b0;
    @(negedge clk);
    run0(0, 0, 0);
    check("after_abort_done_at", done_n, 633);
    check("after_abort_pass", intf0.pass, 1);
    check("after_abort_fail", intf0.fail_vec, 0);
    check("after_abort_err", intf0.err_count, 0);
    @(negedge clk);

    // start and rst in the same cycle: rst wins
    intf0.start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    intf0.start = 1'b0;
    rst = 1'b0;
    check("rst_vs_start_busy", intf0.busy, 0);
    @(negedge clk);
    check("rst_vs_start_idle", intf0.busy, 0);
    check("rst_vs_start_pass", intf0.pass, 0);

    // HOLD_CYCLES = 2 instance, correct block
    intf1.start = 1'b1;
    n = 0;
    done_n = 0;
    mm_cnt = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      intf1.start = 1'b0;
      if ((n - 1) % c_H1 == 0 && n <= 8 * c_H1)
        check("h2_abc_step", {29'd0, intf1.a, intf1.b, intf1.c}, (n - 1) / c_H1);
      if (intf1.mismatch) mm_cnt++;
      if (intf1.done) begin
        done_n = n;
        break;
      end
    end
    check("h2_done_at", done_n, 17);
    check("h2_pass", intf1.pass, 1);
    check("h2_err", intf1.err_count, 0);
    check("h2_mm_cnt", mm_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
